// File: rtl/mxbus_prefetch.sv
// Instruction prefetch queue between the decoder and the instruction BIU.
// Issues one sequential fetch at a time, queues returned words and supports branch redirect.
module mxbus_prefetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_en,
  input  logic                           flush,
  input  logic [ADDR_WIDTH-1:0]          flush_pc,
  output logic [ADDR_WIDTH-1:0]          insp,
  output logic                           ce_n,
  input  logic [DATA_WIDTH-1:0]          insr,
  input  logic                           valid,
  output logic [DATA_WIDTH-1:0]          ir_data,
  output logic [ADDR_WIDTH-1:0]          ir_addr,
  output logic                           ir_valid,
  input  logic                           ir_ready,
  output logic [$clog2(DEPTH+1)-1:0]     fill_level,
  output logic [1:0]                     dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic push;
  logic pop;
  logic not_full;

  // Decoder handshake: an entry transfers on a rising edge where ir_valid and
  // ir_ready are both high; ir_data/ir_addr hold the head entry while ir_valid is high.
  // Bus handshake: ce_n low with insp stable is held until valid is sampled.
  assign push     = (state == REQ) && valid && !flush;
  assign pop      = (count != '0) && ir_ready && !flush;
  assign not_full = (count < CW'(DEPTH));

  assign ir_valid   = (count != '0);
  assign ir_data    = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_addr    = ir_valid ? addr_mem[rd_ptr] : '0;
  assign fill_level = count;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      insp   <= RESET_PC;
      ce_n   <= 1'b1;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            pc <= flush_pc;
          end else if (fetch_en && not_full) begin
            ce_n  <= 1'b0;
            insp  <= pc;
            state <= REQ;
          end
        end
        REQ: begin
          if (valid) begin
            ce_n  <= 1'b1;
            state <= IDLE;
            pc    <= flush ? flush_pc : pc + ADDR_WIDTH'(1);
          end else if (flush) begin
            // The bus cycle cannot be aborted; keep requesting and discard the word.
            pc    <= flush_pc;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush) pc <= flush_pc;
          if (valid) begin
            ce_n  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          ce_n  <= 1'b1;
          state <= IDLE;
        end
      endcase

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= pc;
      data_mem[wr_ptr] <= insr;
    end
  end

endmodule

// File: tb/tb_mxbus_prefetch.sv
// Bench for mxbus_prefetch: BIU slave model, request/queue scoreboards, directed redirect cases.
// Two instances share inputs; the one selected by sel is out of reset and observed.
module tb_mxbus_prefetch;

  logic       clk;
  logic       rst1, rst2;
  logic       fetch_en, flush, valid, ir_ready;
  logic [7:0] flush_pc, insr;
  logic [7:0] insp1, insp2, ir_data1, ir_data2, ir_addr1, ir_addr2;
  logic       ce_n1, ce_n2, ir_valid1, ir_valid2;
  logic [2:0] fill1, fill2;
  logic [1:0] st1, st2;
  logic       sel;

  logic [7:0] m_insp, m_ir_data, m_ir_addr;
  logic       m_ce_n, m_ir_valid, m_rst;
  logic [2:0] m_fill;
  logic [1:0] m_st;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_req_q[$];
  logic [15:0] exp_q[$];
  int          gap_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t tbl_a[3];
  vec_t tbl_f[4];

  mxbus_prefetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst1), .fetch_en(fetch_en), .flush(flush), .flush_pc(flush_pc),
    .insp(insp1), .ce_n(ce_n1), .insr(insr), .valid(valid),
    .ir_data(ir_data1), .ir_addr(ir_addr1), .ir_valid(ir_valid1), .ir_ready(ir_ready),
    .fill_level(fill1), .dbg_state(st1)
  );

  mxbus_prefetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(8'hFE)) u_dut_wrap (
    .clk(clk), .rst(rst2), .fetch_en(fetch_en), .flush(flush), .flush_pc(flush_pc),
    .insp(insp2), .ce_n(ce_n2), .insr(insr), .valid(valid),
    .ir_data(ir_data2), .ir_addr(ir_addr2), .ir_valid(ir_valid2), .ir_ready(ir_ready),
    .fill_level(fill2), .dbg_state(st2)
  );

  assign m_insp     = sel ? insp2     : insp1;
  assign m_ce_n     = sel ? ce_n2     : ce_n1;
  assign m_ir_data  = sel ? ir_data2  : ir_data1;
  assign m_ir_addr  = sel ? ir_addr2  : ir_addr1;
  assign m_ir_valid = sel ? ir_valid2 : ir_valid1;
  assign m_fill     = sel ? fill2     : fill1;
  assign m_st       = sel ? st2       : st1;
  assign m_rst      = sel ? rst2      : rst1;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // BIU slave: valid two cycles after ce_n falls, returning the inverted address.
  initial begin
    int cnt;
    valid = 1'b0;
    insr  = 8'h00;
    cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_rst) begin
        valid = 1'b0;
        cnt   = 0;
      end else if (valid) begin
        valid = 1'b0;
        cnt   = 0;
      end else if (!m_ce_n) begin
        cnt++;
        if (cnt == 3) begin
          valid = 1'b1;
          insr  = ~m_insp;
        end
      end
    end
  end

  // Scoreboard monitor: request addresses and decoder-side transfers.
  logic prev_ce_n = 1'b1;
  int   high_cnt  = 0;
  always @(negedge clk) begin
    if (!m_rst) begin
      prev_ce_n = 1'b1;
      high_cnt  = 0;
    end else begin
      if (prev_ce_n && !m_ce_n) begin
        gap_q.push_back(high_cnt);
        high_cnt = 0;
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got insp 0x%0h, expected no request", m_insp);
        end else begin
          check("req_addr", {24'd0, m_insp}, {24'd0, exp_req_q.pop_front()});
        end
      end
      if (m_ce_n) high_cnt++;
      prev_ce_n = m_ce_n;
      if (m_ir_valid && ir_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got addr 0x%0h data 0x%0h, expected none", m_ir_addr, m_ir_data);
        end else begin
          check("ir_entry", {16'd0, m_ir_addr, m_ir_data}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst1     = 1'b0;
    rst2     = 1'b0;
    flush    = 1'b0;
    flush_pc = 8'h00;
    fetch_en = 1'b0;
    ir_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_req_q.delete();
    exp_q.delete();
    gap_q.delete();
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    if (sel) rst2 = 1'b1;
    else     rst1 = 1'b1;
  endtask

  task automatic wait_req_left(input int n, input string nm);
    int k = 0;
    while (exp_req_q.size() > n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(nm, exp_req_q.size(), n);
  endtask

  task automatic wait_ir_left(input string nm);
    int k = 0;
    while (exp_q.size() > 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    logic [7:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_req_q.push_back(a);
      exp_q.push_back({a, ~a});
      a = a + 8'd1;
    end
  endtask

  initial begin
    int k;
    sel = 1'b0;
    tbl_a[0] = '{addr: 8'h00, data: 8'hFF};
    tbl_a[1] = '{addr: 8'h01, data: 8'hFE};
    tbl_a[2] = '{addr: 8'h02, data: 8'hFD};
    tbl_f[0] = '{addr: 8'hFE, data: 8'h01};
    tbl_f[1] = '{addr: 8'hFF, data: 8'h00};
    tbl_f[2] = '{addr: 8'h00, data: 8'hFF};
    tbl_f[3] = '{addr: 8'h01, data: 8'hFE};

    // reset values
    do_reset();
    @(negedge clk);
    check("rst_ce_n", m_ce_n, 1);
    check("rst_insp", m_insp, 8'h00);
    check("rst_ir_valid", m_ir_valid, 0);
    check("rst_ir_data", m_ir_data, 0);
    check("rst_ir_addr", m_ir_addr, 0);
    check("rst_fill", m_fill, 0);
    check("rst_state", m_st, 0);

    // A: sequential fetch with decoder always ready
    for (int i = 0; i < 3; i++) begin
      exp_req_q.push_back(tbl_a[i].addr);
      exp_q.push_back({tbl_a[i].addr, tbl_a[i].data});
    end
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    release_rst();
    wait_req_left(0, "A_reqs_done");
    fetch_en = 1'b0;
    wait_ir_left("A_ir_done");
    check("A_gap_count", gap_q.size(), 3);
    if (gap_q.size() >= 3) begin
      check("A_gap1", gap_q[1], 1);
      check("A_gap2", gap_q[2], 1);
    end

    // B: decoder stalled fills the queue, one pop lets one more fetch out
    do_reset();
    for (int i = 0; i < 4; i++) exp_req_q.push_back(8'(i));
    fetch_en = 1'b1;
    release_rst();
    wait_req_left(0, "B_four_reqs");
    k = 0;
    while (m_fill != 3'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("B_fill_full", m_fill, 4);
    repeat (6) @(negedge clk);
    check("B_full_ce_n", m_ce_n, 1);
    check("B_head_addr", m_ir_addr, 8'h00);
    check("B_head_data", m_ir_data, 8'hFF);
    exp_req_q.push_back(8'h04);
    exp_q.push_back({8'h00, 8'hFF});
    @(posedge clk); #1; ir_ready = 1'b1;
    @(posedge clk); #1; ir_ready = 1'b0;
    wait_req_left(0, "B_refetch");
    fetch_en = 1'b0;
    repeat (6) @(negedge clk);
    check("B_fill_after", m_fill, 4);
    check("B_head_after", m_ir_addr, 8'h01);
    check("B_pop_done", exp_q.size(), 0);

    // C: redirect while the request is outstanding
    do_reset();
    push_seq(8'h00, 5);
    exp_req_q.push_back(8'h05);
    push_seq(8'h40, 1);
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    release_rst();
    wait_req_left(1, "C_reach_05");
    @(posedge clk); #1; flush = 1'b1; flush_pc = 8'h40;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("C_state_drain", m_st, 2);
    check("C_ce_n_held", m_ce_n, 0);
    check("C_insp_held", m_insp, 8'h05);
    check("C_fill_empty", m_fill, 0);
    check("C_ir_valid", m_ir_valid, 0);
    wait_req_left(0, "C_req_40");
    fetch_en = 1'b0;
    wait_ir_left("C_ir_done");

    // D: redirect in the same cycle as the returning word
    do_reset();
    push_seq(8'h00, 7);
    exp_req_q.push_back(8'h07);
    push_seq(8'h80, 1);
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    release_rst();
    wait_req_left(1, "D_reach_07");
    @(posedge clk);
    @(posedge clk); #1; flush = 1'b1; flush_pc = 8'h80;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("D_state_idle", m_st, 0);
    check("D_ce_n_high", m_ce_n, 1);
    check("D_ir_valid", m_ir_valid, 0);
    wait_req_left(0, "D_req_80");
    fetch_en = 1'b0;
    wait_ir_left("D_ir_done");

    // E: second redirect while draining wins
    do_reset();
    exp_req_q.push_back(8'h00);
    push_seq(8'h90, 1);
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    release_rst();
    wait_req_left(1, "E_reach_00");
    flush = 1'b1;
    flush_pc = 8'h20;
    @(posedge clk); #1; flush_pc = 8'h90;
    @(negedge clk);
    check("E_state_drain1", m_st, 2);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("E_state_drain2", m_st, 2);
    check("E_ce_n_held", m_ce_n, 0);
    wait_req_left(0, "E_req_90");
    fetch_en = 1'b0;
    wait_ir_left("E_ir_done");

    // G: asynchronous reset during an outstanding request
    do_reset();
    exp_req_q.push_back(8'h00);
    exp_req_q.push_back(8'h01);
    fetch_en = 1'b1;
    release_rst();
    wait_req_left(0, "G_reach_01");
    check("G_fill_before", m_fill, 1);
    #2;
    rst1 = 1'b0;
    #1;
    check("G_ce_n", m_ce_n, 1);
    check("G_ir_valid", m_ir_valid, 0);
    check("G_fill", m_fill, 0);
    check("G_state", m_st, 0);
    check("G_insp", m_insp, 8'h00);
    exp_req_q.push_back(8'h00);
    exp_q.push_back({8'h00, 8'hFF});
    ir_ready = 1'b1;
    release_rst();
    wait_req_left(0, "G_req_after");
    fetch_en = 1'b0;
    wait_ir_left("G_ir_done");

    // F: address wrap from RESET_PC=0xFE
    do_reset();
    sel = 1'b1;
    @(negedge clk);
    check("F_rst_insp", m_insp, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      exp_req_q.push_back(tbl_f[i].addr);
      exp_q.push_back({tbl_f[i].addr, tbl_f[i].data});
    end
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    release_rst();
    wait_req_left(0, "F_reqs_done");
    fetch_en = 1'b0;
    wait_ir_left("F_ir_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
